branch_target_predictor: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters. It lets the fetch stage redirect the PC in the same cycle as lookup, instead of waiting for the EX-stage branch or jump resolution. Lookup runs in the fetch stage. Updates come from EX-stage resolution of BEQ/BNE/J/JAL/JR. The block also keeps lookup and mispredict statistics counters for performance analysis.

---
 rtl/branch_target_predictor.sv | 92 +++++++++
 tb/tb_branch_target_predictor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational fetch-stage lookup, registered EX-stage update, saturating stats counters.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              lookup_en,
    input  logic [31:0]       lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              update_en,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic [31:0]       update_target,
    input  logic              update_mispredict,
    input  logic              flush_all,
    output logic [STAT_W-1:0] lookup_count,
    output logic [STAT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [CNT_W-1:0]   cnts    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];

    // Lookup reads the current table only; a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnts[lk_idx][CNT_W-1];
        pred_target = pred_hit ? targets[lk_idx] : '0;
    end

    assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                cnts[i]    <= '0;
            end
        end else if (flush_all) begin
            valid <= '0;
        end else if (update_en) begin
            if (up_hit) begin
                if (update_taken) begin
                    if (cnts[up_idx] != '1)
                        cnts[up_idx] <= cnts[up_idx] + CNT_W'(1);
                    targets[up_idx] <= update_target;
                end else if (cnts[up_idx] != '0) begin
                    cnts[up_idx] <= cnts[up_idx] - CNT_W'(1);
                end
            end else if (update_taken) begin
                valid[up_idx]   <= 1'b1;
                tags[up_idx]    <= up_tag;
                targets[up_idx] <= update_target;
                cnts[up_idx]    <= CNT_WEAK;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookup_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (lookup_en && (lookup_count != '1))
                lookup_count <= lookup_count + STAT_W'(1);
            if (update_en && update_mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed checks of branch_target_predictor against an
// array-based model of the BTB rules (ENTRIES=16, CNT_W=2, STAT_W=4).
module tb_branch_target_predictor;
    localparam int STAT_MAX = 15;
    localparam int CNT_MAX  = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        flush_all;
    logic [3:0]  lookup_count;
    logic [3:0]  mispredict_count;

    int vectors = 0;
    int miscompares = 0;

    branch_target_predictor #(.ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .lookup_en(lookup_en),
        .lookup_pc(lookup_pc),
        .pred_hit(pred_hit),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .update_en(update_en),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .update_target(update_target),
        .update_mispredict(update_mispredict),
        .flush_all(flush_all),
        .lookup_count(lookup_count),
        .mispredict_count(mispredict_count)
    );

    always #5 CLK = ~CLK;

    // Model: each entry held as plain integers; index = (pc/4) mod 16, tag = pc/64.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    int          m_lk;
    int          m_mp;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_tag[i]   = 0;
                m_tgt[i]   = '0;
                m_cnt[i]   = 0;
            end
            m_lk = 0;
            m_mp = 0;
        end else begin
            int unsigned ix;
            int unsigned tg;
            if (lookup_en && m_lk < STAT_MAX) m_lk = m_lk + 1;
            if (update_en && update_mispredict && m_mp < STAT_MAX) m_mp = m_mp + 1;
            ix = (update_pc / 4) % 16;
            tg = update_pc / 64;
            if (flush_all) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 0;
            end else if (update_en) begin
                if (m_valid[ix] && m_tag[ix] == tg) begin
                    if (update_taken) begin
                        m_cnt[ix] = (m_cnt[ix] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[ix] + 1;
                        m_tgt[ix] = update_target;
                    end else begin
                        m_cnt[ix] = (m_cnt[ix] - 1 < 0) ? 0 : m_cnt[ix] - 1;
                    end
                end else if (update_taken) begin
                    m_valid[ix] = 1;
                    m_tag[ix]   = tg;
                    m_tgt[ix]   = update_target;
                    m_cnt[ix]   = 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are checked mid-cycle, away from the rising edge.
    always @(negedge CLK) begin
        int unsigned ix;
        bit          hit;
        ix  = (lookup_pc / 4) % 16;
        hit = m_valid[ix] && (m_tag[ix] == lookup_pc / 64);
        check("pred_hit",    32'(pred_hit),    32'(hit));
        check("pred_taken",  32'(pred_taken),  32'(hit && m_cnt[ix] >= 2));
        check("pred_target", pred_target,      hit ? m_tgt[ix] : 32'h0);
        check("lookup_count",     32'(lookup_count),     32'(m_lk));
        check("mispredict_count", 32'(mispredict_count), 32'(m_mp));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        update_en         = 1'b0;
        update_mispredict = 1'b0;
        flush_all         = 1'b0;
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken,
                             input logic [31:0] tgt, input logic mis);
        update_en         = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_target     = tgt;
        update_mispredict = mis;
    endtask

    task automatic expect_lookup(input string name, input logic h, input logic t,
                                 input logic [31:0] tgt);
        check({name, ".hit"},    32'(pred_hit),   32'(h));
        check({name, ".taken"},  32'(pred_taken), 32'(t));
        check({name, ".target"}, pred_target,     tgt);
    endtask

    initial begin
        logic exp_nt [4];
        exp_nt = '{1'b1, 1'b0, 1'b0, 1'b0};
        RST = 1'b1;
        lookup_en = 1'b0;
        lookup_pc = 32'h40;
        update_en = 1'b0;
        update_pc = '0;
        update_taken = 1'b0;
        update_target = '0;
        update_mispredict = 1'b0;
        flush_all = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        sample();
        expect_lookup("after_reset", 1'b0, 1'b0, 32'h0);

        // Allocation: weakly taken, target written
        do_update(32'h40, 1'b1, 32'h100, 1'b0);
        tick();
        lookup_pc = 32'h40;
        lookup_en = 1'b1;
        sample();
        expect_lookup("alloc", 1'b1, 1'b1, 32'h100);

        // Saturation up, then down to 0 and held there
        repeat (3) begin
            do_update(32'h40, 1'b1, 32'h100, 1'b0);
            tick();
        end
        sample();
        expect_lookup("sat_up", 1'b1, 1'b1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            do_update(32'h40, 1'b0, 32'hDEAD, 1'b0);
            tick();
            sample();
            expect_lookup("sat_down", 1'b1, exp_nt[k], 32'h100);
        end
        do_update(32'h44, 1'b0, 32'h123, 1'b0);
        tick();
        lookup_pc = 32'h44;
        sample();
        expect_lookup("nt_miss_no_alloc", 1'b0, 1'b0, 32'h0);

        // Aliasing on index 0
        do_update(32'h80, 1'b1, 32'h200, 1'b0);
        tick();
        lookup_pc = 32'h80;
        sample();
        expect_lookup("alias_new", 1'b1, 1'b1, 32'h200);
        lookup_pc = 32'h40;
        sample();
        expect_lookup("alias_old", 1'b0, 1'b0, 32'h0);

        // Collision: same-cycle lookup sees pre-update contents
        do_update(32'h40, 1'b1, 32'h100, 1'b0);
        tick();
        do_update(32'h40, 1'b1, 32'h300, 1'b0);
        sample();
        expect_lookup("collide_old", 1'b1, 1'b1, 32'h100);
        tick();
        sample();
        expect_lookup("collide_new", 1'b1, 1'b1, 32'h300);

        // Flush beats a same-cycle allocation
        flush_all = 1'b1;
        do_update(32'h48, 1'b1, 32'h480, 1'b0);
        tick();
        sample();
        expect_lookup("flush_40", 1'b0, 1'b0, 32'h0);
        lookup_pc = 32'h48;
        sample();
        expect_lookup("flush_48", 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-cycle with an update pending
        do_update(32'h40, 1'b1, 32'h100, 1'b0);
        tick();
        lookup_pc = 32'h40;
        sample();
        expect_lookup("pre_reset", 1'b1, 1'b1, 32'h100);
        do_update(32'h40, 1'b1, 32'h500, 1'b1);
        #2 RST = 1'b1;
        #1;
        expect_lookup("async_reset", 1'b0, 1'b0, 32'h0);
        check("async_reset.lk", 32'(lookup_count), 32'h0);
        check("async_reset.mp", 32'(mispredict_count), 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        lookup_en = 1'b0;
        update_en = 1'b0;
        update_mispredict = 1'b0;
        sample();
        expect_lookup("post_reset", 1'b0, 1'b0, 32'h0);

        // Statistics saturation and flush independence
        lookup_en = 1'b1;
        repeat (20) tick();
        lookup_en = 1'b0;
        sample();
        check("lookup_sat", 32'(lookup_count), 32'd15);
        repeat (20) begin
            do_update(32'h3C0, 1'b0, 32'h0, 1'b1);
            tick();
        end
        sample();
        check("mispredict_sat", 32'(mispredict_count), 32'd15);
        flush_all = 1'b1;
        tick();
        sample();
        check("flush_keeps_lk", 32'(lookup_count), 32'd15);
        check("flush_keeps_mp", 32'(mispredict_count), 32'd15);

        // Random traffic over a small PC pool so hits, aliases and collisions recur
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (3000) begin
            lookup_en = 1'($urandom_range(0, 1));
            lookup_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                        | $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 50)
                do_update(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                          | $urandom_range(0, 3),
                          1'($urandom_range(0, 2) != 0), $urandom,
                          1'($urandom_range(0, 7) == 0));
            flush_all = 1'($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 5) begin
                #2 RST = 1'b1;
                @(posedge CLK);
                #1 RST = 1'b0;
            end
            tick();
        end
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
